// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg
// Shared definitions for the instruction fetch stage:
//   AddrLen / InstLen / ByteLen - address, instruction and memory byte widths
//   INST_BUBBLE                 - flushed encoding that decode treats as a bubble
//   fetch_state_e               - fetch FSM state encoding
//   align_word()                - clears the byte offset of an address
package inst_fetch_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;
    localparam int ByteLen = 8;

    // addi x0, x0, 0: architecturally a no-op, so a leaked bubble is harmless
    localparam logic [InstLen-1:0] INST_BUBBLE = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [AddrLen-1:0] align_word(input logic [AddrLen-1:0] addr);
        return addr & ~AddrLen'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// inst_fetch_icache
// Direct-mapped instruction cache, one 32-bit instruction per line.
// Index = word address low bits, tag = remaining upper bits.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (clears valid bits)
//   rd_addr         word address (byte offset dropped) looked up combinationally
//   hit, rd_inst    lookup result
//   wr_en, wr_addr,
//   wr_inst         fill port, written on the rising edge
module inst_fetch_icache
    import inst_fetch_pkg::*;
#(
    parameter int LINES = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AddrLen-1:2]   rd_addr,
    output logic                 hit,
    output logic [InstLen-1:0]   rd_inst,
    input  logic                 wr_en,
    input  logic [AddrLen-1:2]   wr_addr,
    input  logic [InstLen-1:0]   wr_inst
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = AddrLen - 2 - IDX_W;

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [InstLen-1:0] data [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_addr[IDX_W+1:2];
    assign rd_tag = rd_addr[AddrLen-1:IDX_W+2];
    assign wr_idx = wr_addr[IDX_W+1:2];
    assign wr_tag = wr_addr[AddrLen-1:IDX_W+2];

    assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_inst = data[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are qualified by valid, so they need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_inst;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch
// Instruction fetch stage: holds the PC, assembles 32-bit little-endian
// instructions from a byte-wide memory port and presents them to IF/ID under
// a valid/stall handshake. Redirects restart fetch at the word-aligned target.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   rdy                       global ready; low freezes every register
//   mem_req_o, mem_addr_o     byte read request / address
//   mem_ack_i, mem_data_i     byte delivered this cycle
//   stall_i                   IF/ID cannot accept this cycle
//   jmp_valid_i, jmp_addr_i   redirect request / target
//   pc_o, inst_o,
//   inst_valid_o, prediction_o  presented instruction (prediction = pc_o + 4)
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [AddrLen-1:0] RESET_PC     = 32'h0,
    parameter int                 ICACHE_LINES = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    output logic               mem_req_o,
    output logic [AddrLen-1:0] mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [ByteLen-1:0] mem_data_i,
    input  logic               stall_i,
    input  logic               jmp_valid_i,
    input  logic [AddrLen-1:0] jmp_addr_i,
    output logic [AddrLen-1:0] pc_o,
    output logic [InstLen-1:0] inst_o,
    output logic               inst_valid_o,
    output logic [AddrLen-1:0] prediction_o
);

    if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two of at least 2");
    end

    fetch_state_e     state, state_n;
    logic [AddrLen-1:0] pc, pc_n;
    logic [1:0]         cnt, cnt_n;
    // Bytes 0..2 of the instruction being assembled; byte 3 comes straight from memory
    logic [23:0]        byte_buf, buf_n;
    logic               req_n;
    logic [AddrLen-1:0] addr_n;
    logic [AddrLen-1:0] pc_o_n;
    logic [InstLen-1:0] inst_n;
    logic               valid_n;
    logic [AddrLen-1:0] pred_n;

    logic               cache_hit;
    logic [InstLen-1:0] cache_inst;

`ifdef ICACHE_EN
    logic fill;

    // Fill only on a completed, non-redirected fetch so partial lines never land
    assign fill = rdy && !jmp_valid_i && (state == FETCH) && mem_ack_i && (cnt == 2'd3);

    inst_fetch_icache #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (pc[AddrLen-1:2]),
        .hit     (cache_hit),
        .rd_inst (cache_inst),
        .wr_en   (fill),
        .wr_addr (pc[AddrLen-1:2]),
        .wr_inst ({mem_data_i, byte_buf})
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_inst = INST_BUBBLE;
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        buf_n   = byte_buf;
        req_n   = mem_req_o;
        addr_n  = mem_addr_o;
        pc_o_n  = pc_o;
        inst_n  = inst_o;
        valid_n = inst_valid_o;
        pred_n  = prediction_o;

        if (rdy) begin
            if (jmp_valid_i) begin
                // Redirect wins in every state, dropping any partial or held instruction
                pc_n    = align_word(jmp_addr_i);
                state_n = IDLE;
                cnt_n   = 2'd0;
                req_n   = 1'b0;
                valid_n = 1'b0;
                inst_n  = INST_BUBBLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cache_hit) begin
                            pc_o_n  = pc;
                            inst_n  = cache_inst;
                            pred_n  = pc + AddrLen'(4);
                            valid_n = 1'b1;
                            state_n = HOLD;
                        end else begin
                            req_n   = 1'b1;
                            addr_n  = pc;
                            cnt_n   = 2'd0;
                            state_n = FETCH;
                        end
                    end
                    FETCH: begin
                        if (mem_ack_i) begin
                            cnt_n  = cnt + 2'd1;
                            addr_n = mem_addr_o + AddrLen'(1);
                            unique case (cnt)
                                2'd0: buf_n[7:0]   = mem_data_i;
                                2'd1: buf_n[15:8]  = mem_data_i;
                                2'd2: buf_n[23:16] = mem_data_i;
                                default: begin
                                    pc_o_n  = pc;
                                    inst_n  = {mem_data_i, byte_buf};
                                    pred_n  = pc + AddrLen'(4);
                                    valid_n = 1'b1;
                                    req_n   = 1'b0;
                                    state_n = HOLD;
                                end
                            endcase
                        end
                    end
                    HOLD: begin
                        if (!stall_i) begin
                            pc_n    = pc + AddrLen'(4);
                            valid_n = 1'b0;
                            inst_n  = INST_BUBBLE;
                            state_n = IDLE;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            cnt          <= 2'd0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            pc_o         <= '0;
            inst_o       <= INST_BUBBLE;
            inst_valid_o <= 1'b0;
            prediction_o <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            cnt          <= cnt_n;
            mem_req_o    <= req_n;
            mem_addr_o   <= addr_n;
            pc_o         <= pc_o_n;
            inst_o       <= inst_n;
            inst_valid_o <= valid_n;
            prediction_o <= pred_n;
        end
    end

    always_ff @(posedge clk) begin
        byte_buf <= buf_n;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch
// Directed and randomized bench for inst_fetch. A byte memory is modelled as a
// pure function of address; the expected instruction at a PC is the
// little-endian concatenation of the four bytes at PC..PC+3, and the expected
// PC sequence follows sequential +4 advance and word-aligned redirects.
// Cache-specific timing checks are compiled when ICACHE_EN is defined.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_data_i;
    logic        stall_i;
    logic        jmp_valid_i;
    logic [31:0] jmp_addr_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic [31:0] prediction_o;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int ack_pct = 100;

    logic [31:0] exp_pc;
    logic [31:0] jaddr;
    logic [31:0] p;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .stall_i      (stall_i),
        .jmp_valid_i  (jmp_valid_i),
        .jmp_addr_i   (jmp_addr_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .prediction_o (prediction_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0: return 8'h13;
            32'h1: return 8'h05;
            32'h2: return 8'h10;
            32'h3: return 8'h00;
            default: return (a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24]) + 8'h3B;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Memory responder: answers outstanding requests with ack_pct probability
    always @(negedge clk) begin
        if (mem_req_o && ($urandom_range(99, 0) < ack_pct)) begin
            mem_ack_i  = 1'b1;
            mem_data_i = mem_byte(mem_addr_o);
        end else begin
            mem_ack_i  = 1'b0;
            mem_data_i = 8'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid_check(input logic [31:0] epc);
        for (int i = 0; i < 300 && inst_valid_o !== 1'b1; i++) tick();
        chk("valid_within_bound", 32'(inst_valid_o), 32'd1);
        chk("pc_o", pc_o, epc);
        chk("inst_o", inst_o, mem_word(epc));
        chk("prediction_o", prediction_o, epc + 32'd4);
    endtask

    // Hold the instruction for a random number of stall cycles, then consume it
    task automatic consume();
        int n;
        logic [31:0] s_pc;
        logic [31:0] s_inst;
        n = $urandom_range(2, 0);
        s_pc = pc_o;
        s_inst = inst_o;
        stall_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("stall_valid", 32'(inst_valid_o), 32'd1);
            chk("stall_inst", inst_o, s_inst);
            chk("stall_pc", pc_o, s_pc);
        end
        stall_i = 1'b0;
        tick();
        chk("consumed_valid", 32'(inst_valid_o), 32'd0);
        chk("consumed_bubble", inst_o, INST_BUBBLE);
    endtask

    task automatic redirect(input logic [31:0] target);
        jmp_addr_i  = target;
        jmp_valid_i = 1'b1;
        tick();
        jmp_valid_i = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        rdy         = 1'b1;
        stall_i     = 1'b0;
        jmp_valid_i = 1'b0;
        jmp_addr_i  = '0;
        mem_ack_i   = 1'b0;
        mem_data_i  = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_inst", inst_o, INST_BUBBLE);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_pc_o", pc_o, 32'd0);
        chk("rst_pred", prediction_o, 32'd0);

        // First fetch from address 0, ack every cycle: valid 5 edges after release
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("first_req", 32'(mem_req_o), 32'd1);
        chk("first_addr", mem_addr_o, 32'd0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("first_not_yet_valid", 32'(inst_valid_o), 32'd0);
        end
        tick();
        chk("first_valid_edge5", 32'(inst_valid_o), 32'd1);
        chk("first_inst_const", inst_o, 32'h0010_0513);
        wait_valid_check(32'd0);

        // Stall three cycles: outputs frozen, no request
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall3_inst", inst_o, 32'h0010_0513);
            chk("stall3_valid", 32'(inst_valid_o), 32'd1);
            chk("stall3_req", 32'(mem_req_o), 32'd0);
        end
        stall_i = 1'b0;
        tick();
        chk("release_valid", 32'(inst_valid_o), 32'd0);
        tick();
        chk("next_req", 32'(mem_req_o), 32'd1);
        chk("next_addr", mem_addr_o, 32'd4);
        wait_valid_check(32'd4);
        consume();

        // Redirect to 0x1002 after the second byte of the fetch at 8
        tick();
        chk("pre_redir_addr", mem_addr_o, 32'd8);
        tick();
        tick();
        chk("two_acks_addr", mem_addr_o, 32'd10);
        redirect(32'h0000_1002);
        chk("redir_req", 32'(mem_req_o), 32'd0);
        chk("redir_valid", 32'(inst_valid_o), 32'd0);
        chk("redir_inst", inst_o, INST_BUBBLE);
        tick();
        chk("redir_target_req", 32'(mem_req_o), 32'd1);
        chk("redir_target_addr", mem_addr_o, 32'h0000_1000);
        wait_valid_check(32'h0000_1000);

        // Redirect under stall drops the held instruction
        stall_i = 1'b1;
        redirect(32'h0000_0041);
        chk("drop_valid", 32'(inst_valid_o), 32'd0);
        chk("drop_inst", inst_o, INST_BUBBLE);
        stall_i = 1'b0;
        tick();
        chk("drop_target_addr", mem_addr_o, 32'h0000_0040);
        wait_valid_check(32'h0000_0040);
        consume();

        // rdy low for four cycles mid-fetch with acks arriving
        p = 32'h0000_0044;
        tick();
        tick();
        chk("pre_freeze_addr", mem_addr_o, p + 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("freeze_addr", mem_addr_o, p + 32'd1);
            chk("freeze_req", 32'(mem_req_o), 32'd1);
            chk("freeze_valid", 32'(inst_valid_o), 32'd0);
        end
        rdy = 1'b1;
        tick();
        chk("thaw_valid1", 32'(inst_valid_o), 32'd0);
        tick();
        chk("thaw_valid2", 32'(inst_valid_o), 32'd0);
        tick();
        chk("thaw_valid3", 32'(inst_valid_o), 32'd1);
        wait_valid_check(p);
        consume();

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFFE);
        wait_valid_check(32'hFFFF_FFFC);
        consume();
        tick();
        chk("wrap_req", 32'(mem_req_o), 32'd1);
        chk("wrap_addr", mem_addr_o, 32'd0);
        wait_valid_check(32'd0);
        consume();

        // Randomized ack timing, stalls and redirects
        exp_pc = 32'd4;
        for (int n = 0; n < 24; n++) begin
            ack_pct = $urandom_range(100, 25);
            if (n % 6 == 5) begin
                jaddr = $urandom;
                redirect(jaddr);
                exp_pc = {jaddr[31:2], 2'b00};
            end
            wait_valid_check(exp_pc);
            consume();
            exp_pc = exp_pc + 32'd4;
        end
        ack_pct = 100;

`ifdef ICACHE_EN
        // Loop of three instructions: second pass served from the cache
        redirect(32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_valid_check(32'(k * 4));
            consume();
        end
        redirect(32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hit_valid_1edge", 32'(inst_valid_o), 32'd1);
            chk("hit_no_req", 32'(mem_req_o), 32'd0);
            wait_valid_check(32'(k * 4));
            stall_i = 1'b0;
            tick();
            chk("hit_consumed", 32'(inst_valid_o), 32'd0);
        end

        // A redirected partial fetch must not leave a cache line behind
        redirect(32'h0000_200C);
        tick();
        tick();
        tick();
        redirect(32'h0000_0300);
        redirect(32'h0000_200C);
        tick();
        chk("partial_miss_req", 32'(mem_req_o), 32'd1);
        chk("partial_miss_valid", 32'(inst_valid_o), 32'd0);
        wait_valid_check(32'h0000_200C);
        consume();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
